rom_mp: RTL and testbench

ROM_MP -- requirements
Module: rom_mp

---
 rtl/rom_pkg.sv | 26 ++
 rtl/rom_rr_arb.sv | 62 ++++++
 rtl/rom_mp.sv | 148 ++++++++++++++
 tb/tb_rom_mp.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared types and width helpers for the multi-port download ROM.
package rom_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // Ceiling log2 for elaboration-time width calculation.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits for a single channel.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_rr_arb.sv
// Round-robin arbiter: one grant per cycle, searching from last-granted + 1.
module rom_rr_arb
    import rom_pkg::*;
#(
    parameter int unsigned CH = 2,
    localparam int unsigned IW = idx_w(CH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [CH-1:0] req_i,
    output logic [CH-1:0] gnt_c_o,
    output logic [IW-1:0] idx_c_o,
    output logic          vld_c_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [CH-1:0] gnt_c;
    logic [IW-1:0] idx_c;
    logic          vld_c;

    // Two passes: channels above the pointer first, then wrap to the rest.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        vld_c = 1'b0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (!vld_c && req_i[c] && (c > 32'(ptr_q))) begin
                gnt_c[c] = 1'b1;
                idx_c    = IW'(c);
                vld_c    = 1'b1;
            end
        end
        for (int unsigned c = 0; c < CH; c++) begin
            if (!vld_c && req_i[c] && (c <= 32'(ptr_q))) begin
                gnt_c[c] = 1'b1;
                idx_c    = IW'(c);
                vld_c    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && vld_c) begin
            ptr_d = idx_c;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= IW'(CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_c_o = gnt_c;
    assign idx_c_o = idx_c;
    assign vld_c_o = vld_c;

endmodule

// File: rtl/rom_mp.sv
// Multi-channel read ROM with a download port; downloads pre-empt all reads.
module rom_mp
    import rom_pkg::*;
#(
    parameter int unsigned KB = 16,
    parameter int unsigned DW = 8,
    parameter int unsigned CH = 2,
    parameter string       FN = "",
    localparam int unsigned AW = clog2(KB * 8192 / DW)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             dl_en,
    input  logic             dl_wr,
    input  logic [AW-1:0]    dl_a,
    input  logic [DW-1:0]    dl_d,
    output logic             ready,
    output logic [AW:0]      dl_cnt,
    input  logic [CH-1:0]    rd_req,
    input  logic [CH*AW-1:0] rd_a,
    output logic [CH-1:0]    rd_ack,
    output logic [CH*DW-1:0] q
);

    localparam int unsigned DEPTH   = KB * 8192 / DW;
    localparam int unsigned IW      = idx_w(CH);
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CH-1:0] gnt_q, ack_q;
    logic [DW-1:0] q_q [CH];
    logic [DW-1:0] rdata_q;

    logic          grant_en, wr_en, rd_en;
    logic [CH-1:0] arb_gnt;
    logic [IW-1:0] arb_idx;
    logic          arb_vld;
    logic [AW-1:0] rd_a_arr [CH];
    logic [AW-1:0] rd_addr;

    // Reads are only arbitrated in IDLE with no download being requested.
    assign grant_en = (state_q == ST_IDLE) && !dl_en;
    assign wr_en    = (state_q == ST_LOAD) && dl_en && dl_wr;
    assign rd_en    = grant_en && arb_vld;

    // The channel whose read is in flight is masked so a held request acks once.
    rom_rr_arb #(.CH(CH)) u_arb (
        .clk_i   (clock),
        .rst_ni  (nreset),
        .en_i    (grant_en),
        .req_i   (rd_req & ~gnt_q),
        .gnt_c_o (arb_gnt),
        .idx_c_o (arb_idx),
        .vld_c_o (arb_vld)
    );

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            rd_a_arr[c] = rd_a[c*AW +: AW];
        end
        rd_addr = rd_a_arr[arb_idx];
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (dl_en) begin
                    state_d = ST_LOAD;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (!dl_en) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else if (dl_wr && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                q_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            gnt_q   <= rd_en ? arb_gnt : '0;
            ack_q   <= gnt_q;
            for (int unsigned c = 0; c < CH; c++) begin
                if (gnt_q[c]) begin
                    q_q[c] <= rdata_q;
                end
            end
        end
    end

    // Init attribute is only attached when a file is named; contents survive reset.
    if (FN != "") begin : g_mem_init
        (* ram_init_file = FN *) logic [DW-1:0] mem [DEPTH];
        always_ff @(posedge clock) begin
            if (wr_en) begin
                mem[dl_a] <= dl_d;
            end
            if (rd_en) begin
                rdata_q <= mem[rd_addr];
            end
        end
    end else begin : g_mem
        logic [DW-1:0] mem [DEPTH];
        always_ff @(posedge clock) begin
            if (wr_en) begin
                mem[dl_a] <= dl_d;
            end
            if (rd_en) begin
                rdata_q <= mem[rd_addr];
            end
        end
    end

    always_comb begin
        q = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            q[c*DW +: DW] = q_q[c];
        end
    end

    assign ready  = ready_q;
    assign dl_cnt = cnt_q;
    assign rd_ack = ack_q;

endmodule

// File: tb/tb_rom_mp.sv
// Self-checking bench for rom_mp (KB=1, DW=8, CH=2) against a word-array model.
module tb_rom_mp;

    localparam int unsigned CH    = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    logic             clock = 1'b0;
    logic             nreset;
    logic             dl_en;
    logic             dl_wr;
    logic [AW-1:0]    dl_a;
    logic [DW-1:0]    dl_d;
    logic             ready;
    logic [AW:0]      dl_cnt;
    logic [CH-1:0]    rd_req;
    logic [CH*AW-1:0] rd_a;
    logic [CH-1:0]    rd_ack;
    logic [CH*DW-1:0] q;

    logic [DW-1:0] mdl [DEPTH];
    int unsigned   wlist [$];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clock = ~clock;

    rom_mp #(.KB(1), .DW(8), .CH(2), .FN("")) dut (
        .clock  (clock),
        .nreset (nreset),
        .dl_en  (dl_en),
        .dl_wr  (dl_wr),
        .dl_a   (dl_a),
        .dl_d   (dl_d),
        .ready  (ready),
        .dl_cnt (dl_cnt),
        .rd_req (rd_req),
        .rd_a   (rd_a),
        .rd_ack (rd_ack),
        .q      (q)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mdl_wr(input int unsigned a, input logic [DW-1:0] d);
        mdl[a] = d;
        wlist.push_back(a);
    endtask

    task automatic test_reset();
        nreset = 1'b0; dl_en = 1'b0; dl_wr = 1'b0; dl_a = '0; dl_d = '0;
        rd_req = '0; rd_a = '0;
        #13;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (dl_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", dl_cnt); end
        n_cmp++; if (rd_ack !== '0) begin n_bad++; $display("FAIL reset_ack: got %b want 00", rd_ack); end
        n_cmp++; if (q !== '0) begin n_bad++; $display("FAIL reset_q: got %h want 0000", q); end
        @(negedge clock);
        nreset = 1'b1;
        step();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_post: got %b want 1", ready); end
    endtask

    task automatic test_load();
        dl_en = 1'b1;
        step();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_low: got %b want 0", ready); end
        dl_wr = 1'b1; dl_a = 10'h000; dl_d = 8'hA5; mdl_wr(0, 8'hA5);
        step();
        dl_a = 10'h3FF; dl_d = 8'h5A; mdl_wr(10'h3FF, 8'h5A);
        step();
        n_cmp++; if (dl_cnt !== 11'd2) begin n_bad++; $display("FAIL load_cnt: got %0d want 2", dl_cnt); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_held: got %b want 0", ready); end
        dl_wr = 1'b0; dl_en = 1'b0;
        step();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_back: got %b want 1", ready); end
        n_cmp++; if (dl_cnt !== 11'd2) begin n_bad++; $display("FAIL load_cnt_after: got %0d want 2", dl_cnt); end
    endtask

    task automatic test_dual();
        rd_a = {10'h3FF, 10'h000};
        rd_req = 2'b11;
        step();
        n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL dual_t1: got %b want 00", rd_ack); end
        step();
        n_cmp++; if (rd_ack !== 2'b01) begin n_bad++; $display("FAIL dual_ack0: got %b want 01", rd_ack); end
        n_cmp++; if (q[7:0] !== 8'hA5) begin n_bad++; $display("FAIL dual_q0: got %h want a5", q[7:0]); end
        rd_req[0] = 1'b0;
        step();
        n_cmp++; if (rd_ack !== 2'b10) begin n_bad++; $display("FAIL dual_ack1: got %b want 10", rd_ack); end
        n_cmp++; if (q[15:8] !== 8'h5A) begin n_bad++; $display("FAIL dual_q1: got %h want 5a", q[15:8]); end
        rd_req[1] = 1'b0;
        step();
        n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL dual_quiet: got %b want 00", rd_ack); end
        n_cmp++; if (q[7:0] !== 8'hA5) begin n_bad++; $display("FAIL dual_q0_hold: got %h want a5", q[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_seq [6] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        rd_a = {10'h3FF, 10'h000};
        rd_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++; if (rd_ack !== exp_seq[i]) begin n_bad++; $display("FAIL b2b_seq[%0d]: got %b want %b", i, rd_ack, exp_seq[i]); end
            if (exp_seq[i][0]) begin
                n_cmp++; if (q[7:0] !== 8'hA5) begin n_bad++; $display("FAIL b2b_q0[%0d]: got %h want a5", i, q[7:0]); end
            end
            if (exp_seq[i][1]) begin
                n_cmp++; if (q[15:8] !== 8'h5A) begin n_bad++; $display("FAIL b2b_q1[%0d]: got %h want 5a", i, q[15:8]); end
            end
        end
        rd_req = 2'b00;
        step();
        n_cmp++; if (rd_ack !== 2'b10) begin n_bad++; $display("FAIL b2b_tail: got %b want 10", rd_ack); end
        step();
        n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL b2b_idle: got %b want 00", rd_ack); end
        // single held request is acked once and then released
        rd_req = 2'b01;
        step();
        n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL single_t1: got %b want 00", rd_ack); end
        step();
        n_cmp++; if (rd_ack !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b want 01", rd_ack); end
        rd_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL single_double[%0d]: got %b want 00", i, rd_ack); end
        end
    endtask

    task automatic test_dl_during_grant();
        rd_a = {10'h000, 10'h000};
        rd_req = 2'b01;
        step();
        n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL dlg_t1: got %b want 00", rd_ack); end
        dl_en = 1'b1;
        step();
        n_cmp++; if (rd_ack !== 2'b01) begin n_bad++; $display("FAIL dlg_ack: got %b want 01", rd_ack); end
        n_cmp++; if (q[7:0] !== 8'hA5) begin n_bad++; $display("FAIL dlg_prewrite: got %h want a5", q[7:0]); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL dlg_ready: got %b want 0", ready); end
        rd_req = 2'b00;
        dl_wr = 1'b1; dl_a = 10'h000; dl_d = 8'h11; mdl_wr(0, 8'h11);
        step();
        dl_wr = 1'b0;
        rd_req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL dlg_blocked[%0d]: got %b want 00", i, rd_ack); end
        end
        n_cmp++; if (dl_cnt !== 11'd1) begin n_bad++; $display("FAIL dlg_cnt: got %0d want 1", dl_cnt); end
        dl_en = 1'b0;
        step();
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL dlg_ready_back: got %b want 1", ready); end
        step();
        n_cmp++; if (rd_ack !== 2'b00) begin n_bad++; $display("FAIL dlg_grant_cycle: got %b want 00", rd_ack); end
        step();
        n_cmp++; if (rd_ack !== 2'b10) begin n_bad++; $display("FAIL dlg_late_ack: got %b want 10", rd_ack); end
        n_cmp++; if (q[15:8] !== 8'h11) begin n_bad++; $display("FAIL dlg_late_q1: got %h want 11", q[15:8]); end
        rd_req = 2'b00;
        step();
    endtask

    task automatic test_reset_midload();
        int unsigned   addrs [5];
        logic [DW-1:0] dat [5];
        int unsigned   base;
        int            w;
        base = $urandom_range(1, 800);
        dl_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            addrs[i] = base + 37 * i;
            dat[i]   = DW'($urandom_range(1, 255));
            dl_wr = 1'b1; dl_a = AW'(addrs[i]); dl_d = dat[i];
            mdl_wr(addrs[i], dat[i]);
            step();
        end
        dl_wr = 1'b0;
        n_cmp++; if (dl_cnt !== 11'd5) begin n_bad++; $display("FAIL rst_mid_cnt_pre: got %0d want 5", dl_cnt); end
        #2 nreset = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
        n_cmp++; if (dl_cnt !== '0) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d want 0", dl_cnt); end
        n_cmp++; if (rd_ack !== '0) begin n_bad++; $display("FAIL rst_mid_ack: got %b want 00", rd_ack); end
        n_cmp++; if (q !== '0) begin n_bad++; $display("FAIL rst_mid_q: got %h want 0000", q); end
        dl_en = 1'b0;
        #1 nreset = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            rd_a[AW-1:0] = AW'(addrs[i]);
            rd_req[0] = 1'b1;
            w = 0;
            while (rd_ack[0] !== 1'b1 && w < 6) begin
                step();
                w++;
            end
            n_cmp++;
            if (rd_ack[0] !== 1'b1) begin
                n_bad++; $display("FAIL rst_mid_read_timeout[%0d]: got no ack want ack", i);
            end else if (q[7:0] !== dat[i]) begin
                n_bad++; $display("FAIL rst_mid_read[%0d]: got %h want %h", i, q[7:0], dat[i]);
            end
            rd_req[0] = 1'b0;
            step();
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] pend;
        int unsigned   ea [CH];
        int            age [CH];
        int            nw;
        int            len;
        for (int ph = 0; ph < 6; ph++) begin
            dl_en = 1'b1;
            step();
            n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rnd_ready_load[%0d]: got %b want 0", ph, ready); end
            nw  = 0;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    dl_wr = 1'b1;
                    dl_a  = AW'($urandom_range(0, DEPTH - 1));
                    dl_d  = DW'($urandom);
                    mdl_wr(32'(dl_a), dl_d);
                    nw++;
                end else begin
                    dl_wr = 1'b0;
                end
                step();
            end
            dl_wr = 1'b0; dl_en = 1'b0;
            step();
            n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready_idle[%0d]: got %b want 1", ph, ready); end
            n_cmp++; if (dl_cnt !== 11'(nw)) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", ph, dl_cnt, nw); end
            pend = '0;
            for (int s = 0; s < 70; s++) begin
                for (int c = 0; c < CH; c++) begin
                    if (rd_ack[c] === 1'b1) begin
                        n_cmp++;
                        if (!pend[c]) begin
                            n_bad++; $display("FAIL rnd_spurious_ack ch%0d: got ack want none", c);
                        end else if (q[c*DW +: DW] !== mdl[ea[c]]) begin
                            n_bad++; $display("FAIL rnd_data ch%0d addr %h: got %h want %h", c, ea[c], q[c*DW +: DW], mdl[ea[c]]);
                        end
                        pend[c] = 1'b0; rd_req[c] = 1'b0;
                    end else if (pend[c]) begin
                        age[c]++;
                        if (age[c] > 6) begin
                            n_cmp++; n_bad++;
                            $display("FAIL rnd_timeout ch%0d: got no ack want ack within 6 cycles", c);
                            pend[c] = 1'b0; rd_req[c] = 1'b0;
                        end
                    end else if (s < 60 && $urandom_range(0, 1) == 1) begin
                        ea[c] = wlist[$urandom_range(0, wlist.size() - 1)];
                        rd_a[c*AW +: AW] = AW'(ea[c]);
                        rd_req[c] = 1'b1; pend[c] = 1'b1; age[c] = 0;
                    end
                end
                // stray write strobes outside a session must not touch memory
                dl_wr = ($urandom_range(0, 3) == 0);
                dl_a  = AW'($urandom_range(0, DEPTH - 1));
                dl_d  = DW'($urandom);
                step();
            end
            dl_wr = 1'b0; rd_req = '0;
            n_cmp++; if (pend !== '0) begin n_bad++; $display("FAIL rnd_drain[%0d]: got pending %b want 00", ph, pend); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_dual();
        test_back_to_back();
        test_dl_during_grant();
        test_reset_midload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
